// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: decoded word, its strobes and the busy flag.
// The receiver drives it through the master modport; consumers use the slave modport.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, centre-sampled from a synchronised rx.
// Good words strobe rx_valid; a low stop bit strobes frame_err and leaves rx_data unchanged.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      rx,
    uart_rx_if.master rx_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (!rx_s) state_nxt = START;
                START: if (cnt == HALF_M1) state_nxt = rx_s ? IDLE : DATA;
                DATA:  if (cnt == LAST && bit_idx == IDX_LAST) state_nxt = STOP;
                STOP:  if (cnt == LAST) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (!en) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: cnt <= '0;
                    START: begin
                        if (cnt == HALF_M1) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == LAST) begin
                            // Right shift lands data bit k at position k after DATA_BITS samples.
                            shift   <= {rx_s, shift[DATA_BITS-1:1]};
                            cnt     <= '0;
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    assign rx_if.rx_data   = rx_data;
    assign rx_if.rx_valid  = rx_valid;
    assign rx_if.frame_err = frame_err;
    assign rx_if.busy      = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clks/bit, 8 data bits: normal, back-to-back,
// glitch, framing error, enable abort and mid-frame reset.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int DB  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .rx    (rx),
        .rx_if (rx_if.master)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_pass    = 0;
    int         cyc       = 0;
    int         valid_cnt = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         t_fall    = 0;
    int         t_valid   = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] log_q[$];
    int         v0;
    int         e0;

    always @(posedge clk) cyc++;

    // Strobe monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (rx_if.rx_valid) begin
            valid_cnt++;
            log_q.push_back(rx_if.rx_data);
            t_valid = cyc;
        end
        if (rx_if.frame_err) err_cnt++;
        if (rx_if.rx_valid && rx_if.frame_err) both_cnt++;
        if (rx_if.busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic int log_at(input int i);
        return (log_q.size() > i) ? int'(log_q[i]) : -1;
    endfunction

    // Called on a falling edge; drives one whole frame at the bit rate. abort_bit >= 0 drops
    // en (and pulses rst_n if use_reset) halfway through that data bit; en stays low to frame end.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit,
                              input bit use_reset);
        t_fall = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                repeat (CPB / 2) @(negedge clk);
                check("pre_abort_busy", int'(rx_if.busy), 1);
                en = 1'b0;
                if (use_reset) rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check("abort_busy", int'(rx_if.busy), 0);
                if (use_reset) begin
                    check("rst_mid_rx_data", int'(rx_if.rx_data), 0);
                    check("rst_mid_rx_valid", int'(rx_if.rx_valid), 0);
                    check("rst_mid_frame_err", int'(rx_if.frame_err), 0);
                    rst_n = 1'b1;
                end
                repeat (CPB / 2 - 2) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rx_data", int'(rx_if.rx_data), 0);
        check("reset_rx_valid", int'(rx_if.rx_valid), 0);
        check("reset_frame_err", int'(rx_if.frame_err), 0);
        check("reset_busy", int'(rx_if.busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        en = 1'b1;
        v0 = valid_cnt; e0 = err_cnt; log_q.delete();
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("a5_valid_pulses", valid_cnt - v0, 1);
        check("a5_data", log_at(0), 'hA5);
        check("a5_frame_err", err_cnt - e0, 0);
        check("a5_rx_data_held", int'(rx_if.rx_data), 'hA5);
        check("a5_latency_window", int'((t_valid - t_fall) >= 150 && (t_valid - t_fall) <= 160), 1);

        v0 = valid_cnt; e0 = err_cnt; log_q.delete();
        send_frame(8'h00, 1'b1, -1, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_valid_pulses", valid_cnt - v0, 2);
        check("b2b_first", log_at(0), 'h00);
        check("b2b_second", log_at(1), 'hFF);
        check("b2b_frame_err", err_cnt - e0, 0);

        v0 = valid_cnt; e0 = err_cnt; busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_busy_seen", int'(busy_seen), 1);
        check("glitch_busy_idle", int'(rx_if.busy), 0);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_frame_err", err_cnt - e0, 0);

        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("ferr_pulses", err_cnt - e0, 1);
        check("ferr_valid", valid_cnt - v0, 0);
        check("ferr_rx_data_kept", int'(rx_if.rx_data), 'hFF);

        v0 = valid_cnt; e0 = err_cnt; log_q.delete();
        send_frame(8'h5A, 1'b1, 3, 1'b0);
        en = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("en_abort_valid_pulses", valid_cnt - v0, 1);
        check("en_abort_data", log_at(0), 'h81);
        check("en_abort_frame_err", err_cnt - e0, 0);

        v0 = valid_cnt; e0 = err_cnt; log_q.delete();
        send_frame(8'h5A, 1'b1, 3, 1'b1);
        en = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("rst_abort_valid_pulses", valid_cnt - v0, 1);
        check("rst_abort_data", log_at(0), 'h81);
        check("rst_abort_frame_err", err_cnt - e0, 0);

        check("never_both_strobes", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
